bldc_commutation_sequencer: RTL and testbench
=============================================

BLDC_COMMUTATION_SEQUENCER -- requirements
Module: bldc_commutation_sequencer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles required to accept a new hall code.
REQ-002 SHALL have parameter DEADTIME_CYCLES, default 32: cycles with drive disabled before run start, direction change or stop completes.
REQ-003 SHALL have parameter STALL_CYCLES, default 1048576: cycles without a commutation in RUN before a stall fault.
REQ-004 SHALL have port clk, input, 1: single clock.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port hall_raw, input, 3: unsynchronised hall sensor inputs.
REQ-007 SHALL have port run_req, input, 1: level request to drive the motor.
REQ-008 SHALL have port dir_req, input, 1: requested direction, same polarity as the commutation sign input.
REQ-009 SHALL have port fault_clr, input, 1: single-cycle fault acknowledge.
REQ-010 SHALL have port hall_out, output, 3: debounced hall code for the commutation logic.
REQ-011 SHALL have port sign, output, 1: direction applied to the commutation logic.
REQ-012 SHALL have port drive_en, output, 1: high only in RUN; downstream gating is pwm & drive_en.
REQ-013 SHALL have port comm_pulse, output, 1: one-cycle pulse when hall_out changes.
REQ-014 SHALL have port fault, output, 1: high in FAULT.
REQ-015 SHALL have port state, output, 2: current FSM state.

Function
REQ-016 SHALL synchronise hall_raw through two flops, then update hall_out only after the synchronised value differs from hall_out and holds for DEBOUNCE_CYCLES consecutive cycles; any glitch restarts the count; worst-case latency from hall_raw to hall_out is DEBOUNCE_CYCLES+2 cycles.
REQ-017 SHALL assert comm_pulse in the same cycle hall_out takes its new value.
REQ-018 SHALL implement states IDLE=0, RUN=1, DEADTIME=2, FAULT=3.
REQ-019 SHALL move IDLE->DEADTIME when run_req=1 and hall_out is neither 000 nor 111; sign loads dir_req on entry.
REQ-020 SHALL move DEADTIME->RUN after exactly DEADTIME_CYCLES cycles if run_req=1, else ->IDLE.
REQ-021 SHALL move RUN->DEADTIME when run_req=0 or dir_req!=sign; in the direction case sign loads dir_req on DEADTIME exit, never while drive_en=1.
REQ-022 SHALL move RUN->FAULT when hall_out becomes 000 or 111, or when the stall counter reaches STALL_CYCLES; the stall counter clears on RUN entry and on every comm_pulse.
REQ-023 SHALL move FAULT->IDLE only on fault_clr=1 with run_req=0; fault_clr at any other time or state is ignored.
REQ-024 SHALL give fault entry priority over every other RUN transition in the same cycle.
REQ-025 SHALL let a dir_req toggle during DEADTIME take effect at DEADTIME exit, with no second dead-time.
REQ-026 SHALL drive drive_en=0 combinationally in every state except RUN, with no pipeline delay on leaving RUN.

Reset
REQ-027 SHALL, while rst=1, force state=IDLE, hall_out=000, sign=0, drive_en=0, comm_pulse=0, fault=0, and all counters and sync flops to 0, including mid-DEADTIME or mid-debounce.
REQ-028 SHALL, after reset release, not assert comm_pulse until the debounce has accepted a first valid code.

Configuration
REQ-029 SHALL, with BLDC_SPEED_MEAS_EN defined, add output period (24 bits): cycles between successive comm_pulses, latched on comm_pulse, saturating at 0xFFFFFF, reset 0, and cleared to 0 in FAULT.
REQ-030 SHALL, without BLDC_SPEED_MEAS_EN, have no period port and no period counter; all other behaviour is unchanged.

Structure
REQ-031 SHALL take the state encoding, HALL_INVALID_LO=000 and HALL_INVALID_HI=111 from shared package bldc_pkg.
REQ-032 SHALL implement the sync and debounce in sub-module hall_debounce (ports clk, rst, hall_raw, hall_out, comm_pulse).

Verification
REQ-033 SHALL cover: hall_raw 001->011 held 18 cycles -> hall_out=011 and one comm_pulse at cycle 18; a 5-cycle glitch -> no change.
REQ-034 SHALL cover: run_req=1, valid hall, dir_req=1 -> DEADTIME for 32 cycles, then RUN with drive_en=1 and sign=1.
REQ-035 SHALL cover: in RUN, dir_req 1->0 -> drive_en=0 next cycle, sign stays 1 for 32 cycles, then sign=0 and RUN resumes.
REQ-036 SHALL cover: in RUN, hall_raw 111 held -> FAULT with fault=1; fault_clr with run_req=1 -> stays in FAULT; fault_clr with run_req=0 -> IDLE.
REQ-037 SHALL cover: STALL_CYCLES=100 and a frozen hall in RUN -> FAULT at the 100th cycle; with BLDC_SPEED_MEAS_EN, commutations every 500 cycles -> period=500.
REQ-038 SHALL cover: rst asserted mid-DEADTIME -> all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/bldc_pkg.sv
// Shared definitions for the BLDC commutation sequencer: FSM state encoding,
// the two hall codes that can never occur on a healthy sensor, and the period width.
package bldc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_DEADTIME = 2'd2,
    ST_FAULT    = 2'd3
  } state_t;

  localparam logic [2:0] HALL_INVALID_LO = 3'b000;
  localparam logic [2:0] HALL_INVALID_HI = 3'b111;
  localparam int         PERIOD_W        = 24;

  function automatic logic hall_valid(input logic [2:0] code);
    return (code != HALL_INVALID_LO) && (code != HALL_INVALID_HI);
  endfunction

endpackage

// File: rtl/hall_debounce.sv
// Two-flop synchroniser plus debounce for the hall inputs; a new code is accepted
// after it has been seen unchanged for DEBOUNCE_CYCLES cycles and pulses comm_pulse.
module hall_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] hall_raw,
  output logic [2:0] hall_out,
  output logic       comm_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic [2:0]       cand;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // A different candidate restarts the run of stable samples at one
  always_comb begin
    cnt_next = (sync2 == cand) ? cnt + CNT_W'(1) : CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1      <= 3'b000;
      sync2      <= 3'b000;
      cand       <= 3'b000;
      cnt        <= '0;
      hall_out   <= 3'b000;
      comm_pulse <= 1'b0;
    end else begin
      sync1      <= hall_raw;
      sync2      <= sync1;
      comm_pulse <= 1'b0;
      if (sync2 == hall_out) begin
        cnt <= '0;
      end else if (cnt_next >= CNT_W'(DEBOUNCE_CYCLES)) begin
        hall_out   <= sync2;
        comm_pulse <= 1'b1;
        cnt        <= '0;
      end else begin
        cand <= sync2;
        cnt  <= cnt_next;
      end
    end
  end

endmodule

// File: rtl/bldc_commutation_sequencer.sv
// BLDC run/dead-time/fault sequencer around a debounced hall code.
// Define BLDC_SPEED_MEAS_EN to add the 24-bit commutation period output.
module bldc_commutation_sequencer
  import bldc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DEADTIME_CYCLES = 32,
  parameter int STALL_CYCLES    = 1048576
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          hall_raw,
  input  logic                run_req,
  input  logic                dir_req,
  input  logic                fault_clr,
  output logic [2:0]          hall_out,
  output logic                sign,
  output logic                drive_en,
  output logic                comm_pulse,
  output logic                fault,
  output logic [1:0]          state
`ifdef BLDC_SPEED_MEAS_EN
  ,
  output logic [PERIOD_W-1:0] period
`endif
);

  localparam int DT_W = $clog2(DEADTIME_CYCLES + 1);
  localparam int ST_W = $clog2(STALL_CYCLES + 1);

  state_t          cur;
  state_t          nxt;
  logic            sign_load;
  logic            hall_bad;
  logic            dt_done;
  logic            stall_hit;
  logic [DT_W-1:0] dt_cnt;
  logic [ST_W-1:0] stall_cnt;

  hall_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_hall_debounce (
    .clk       (clk),
    .rst       (rst),
    .hall_raw  (hall_raw),
    .hall_out  (hall_out),
    .comm_pulse(comm_pulse)
  );

  assign hall_bad  = !hall_valid(hall_out);
  assign dt_done   = (dt_cnt == DT_W'(DEADTIME_CYCLES - 1));
  assign stall_hit = !comm_pulse && (stall_cnt == ST_W'(STALL_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur <= ST_IDLE;
    end else begin
      cur <= nxt;
    end
  end

  // sign only ever changes on a transition out of IDLE or out of DEADTIME,
  // so it is stable whenever drive_en is high
  always_comb begin
    nxt       = cur;
    sign_load = 1'b0;
    case (cur)
      ST_IDLE: begin
        if (run_req && !hall_bad) begin
          nxt       = ST_DEADTIME;
          sign_load = 1'b1;
        end
      end
      ST_DEADTIME: begin
        if (dt_done) begin
          nxt       = run_req ? ST_RUN : ST_IDLE;
          sign_load = 1'b1;
        end
      end
      ST_RUN: begin
        if (hall_bad || stall_hit) begin
          nxt = ST_FAULT;
        end else if (!run_req || (dir_req != sign)) begin
          nxt = ST_DEADTIME;
        end
      end
      ST_FAULT: begin
        if (fault_clr && !run_req) begin
          nxt = ST_IDLE;
        end
      end
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dt_cnt    <= '0;
      stall_cnt <= '0;
      sign      <= 1'b0;
    end else begin
      dt_cnt    <= (cur == ST_DEADTIME && !dt_done) ? dt_cnt + DT_W'(1) : '0;
      stall_cnt <= (cur == ST_RUN && !comm_pulse) ? stall_cnt + ST_W'(1) : '0;
      if (sign_load) begin
        sign <= dir_req;
      end
    end
  end

  assign state    = cur;
  assign drive_en = (cur == ST_RUN);
  assign fault    = (cur == ST_FAULT);

`ifdef BLDC_SPEED_MEAS_EN
  localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;

  logic [PERIOD_W-1:0] per_cnt;
  logic [PERIOD_W-1:0] per_q;

  // per_cnt holds cycles since the last pulse minus one, so the latched value is per_cnt+1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt <= '0;
      per_q   <= '0;
    end else if (cur == ST_FAULT) begin
      per_cnt <= '0;
      per_q   <= '0;
    end else if (comm_pulse) begin
      per_q   <= (per_cnt == PERIOD_MAX) ? PERIOD_MAX : per_cnt + PERIOD_W'(1);
      per_cnt <= '0;
    end else if (per_cnt != PERIOD_MAX) begin
      per_cnt <= per_cnt + PERIOD_W'(1);
    end
  end

  assign period = (cur == ST_FAULT) ? '0 : per_q;
`endif

endmodule

// File: tb/tb_bldc_commutation_sequencer.sv
// Self-checking bench for bldc_commutation_sequencer: directed scenarios plus a
// randomized phase, all compared every cycle against an event-timestamp reference model.
`timescale 1ns/1ps
module tb_bldc_commutation_sequencer;

  localparam int DEB   = 16;
  localparam int DT    = 32;
  localparam int STALL = 100;
  localparam int PMAX  = 16777215;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] hall_raw = 3'b001;
  logic       run_req = 1'b0;
  logic       dir_req = 1'b0;
  logic       fault_clr = 1'b0;
  logic [2:0] hall_out;
  logic       sign;
  logic       drive_en;
  logic       comm_pulse;
  logic       fault;
  logic [1:0] state;
`ifdef BLDC_SPEED_MEAS_EN
  logic [23:0] period;
`endif

  bldc_commutation_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .DEADTIME_CYCLES(DT),
    .STALL_CYCLES   (STALL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hall_raw  (hall_raw),
    .run_req   (run_req),
    .dir_req   (dir_req),
    .fault_clr (fault_clr),
    .hall_out  (hall_out),
    .sign      (sign),
    .drive_en  (drive_en),
    .comm_pulse(comm_pulse),
    .fault     (fault),
    .state     (state)
`ifdef BLDC_SPEED_MEAS_EN
    ,
    .period    (period)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: states as plain integers 0..3, timing kept as edge timestamps
  int         m_state;
  logic [2:0] m_hall;
  bit         m_pulse;
  bit         m_sign;
  int         cyc;
  int         dt_start;
  int         stall_ref;
  int         last_pulse;
  int         m_period;
  logic [2:0] hist[$];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic modelReset();
    m_state = 0; m_hall = 3'b000; m_pulse = 0; m_sign = 0;
    cyc = 0; dt_start = 0; stall_ref = 0; last_pulse = 0; m_period = 0;
    hist.delete();
    for (int i = 0; i < DEB + 2; i++) hist.push_back(3'b000);
  endtask

  // One clock edge: hist keeps the raw samples; the oldest DEB entries are what the
  // synchronised hall looked like over the last DEB cycles.
  task automatic modelStep();
    int         ps;
    logic [2:0] ph;
    logic [2:0] v;
    bit         pp;
    bit         stable;
    bit         bad;
    ps = m_state; ph = m_hall; pp = m_pulse;
    cyc++;
    hist.push_back(hall_raw);
    void'(hist.pop_front());
    v = hist[0];
    stable = 1;
    for (int i = 1; i < DEB; i++) if (hist[i] !== v) stable = 0;
    m_pulse = stable && (v !== ph);
    if (m_pulse) m_hall = v;
    bad = (ph == 3'b000) || (ph == 3'b111);
    case (ps)
      0: if (run_req && !bad) begin
           m_state = 2; m_sign = dir_req; dt_start = cyc;
         end
      2: if (cyc - dt_start >= DT) begin
           m_sign = dir_req;
           if (run_req) begin m_state = 1; stall_ref = cyc; end
           else m_state = 0;
         end
      1: if (bad || (!pp && (cyc - stall_ref >= STALL))) begin
           m_state = 3;
         end else begin
           if (pp) stall_ref = cyc;
           if (!run_req || (dir_req != m_sign)) begin m_state = 2; dt_start = cyc; end
         end
      default: if (fault_clr && !run_req) m_state = 0;
    endcase
    if (ps == 3) begin
      m_period = 0; last_pulse = cyc;
    end else if (pp) begin
      m_period = (cyc - last_pulse > PMAX) ? PMAX : cyc - last_pulse;
      last_pulse = cyc;
    end
  endtask

  task automatic compareAll();
    checkOutput("state", 32'(state), 32'(m_state));
    checkOutput("hall_out", 32'(hall_out), 32'(m_hall));
    checkOutput("comm_pulse", 32'(comm_pulse), 32'(m_pulse));
    checkOutput("sign", 32'(sign), 32'(m_sign));
    checkOutput("drive_en", 32'(drive_en), 32'(m_state == 1));
    checkOutput("fault", 32'(fault), 32'(m_state == 3));
`ifdef BLDC_SPEED_MEAS_EN
    checkOutput("period", 32'(period), (m_state == 3) ? 32'd0 : 32'(m_period));
`endif
  endtask

  task automatic applyStimulus(input logic [2:0] h, input logic r, input logic d, input logic c);
    hall_raw = h; run_req = r; dir_req = d; fault_clr = c;
  endtask

  // fault_clr is only ever held for the first cycle of a tick run
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      modelStep();
      @(negedge clk);
      fault_clr = 1'b0;
      compareAll();
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_state"}, 32'(state), 32'd0);
    checkOutput({tag, "_hall"}, 32'(hall_out), 32'd0);
    checkOutput({tag, "_sign"}, 32'(sign), 32'd0);
    checkOutput({tag, "_drive"}, 32'(drive_en), 32'd0);
    checkOutput({tag, "_pulse"}, 32'(comm_pulse), 32'd0);
    checkOutput({tag, "_fault"}, 32'(fault), 32'd0);
`ifdef BLDC_SPEED_MEAS_EN
    checkOutput({tag, "_period"}, 32'(period), 32'd0);
`endif
  endtask

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    modelReset();
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst = 1'b0;
    modelReset();

    // Debounce: accept 001, then 011 appears exactly DEB+2 edges after the change
    tick(30);
    applyStimulus(3'b011, 0, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (i == 17) checkOutput("deb_before", 32'(hall_out), 32'h1);
      if (i == 18) begin
        checkOutput("deb_pulse", 32'(comm_pulse), 32'h1);
        checkOutput("deb_hall", 32'(hall_out), 32'h3);
      end
      if (i == 19) checkOutput("deb_single", 32'(comm_pulse), 32'h0);
    end
    applyStimulus(3'b010, 0, 0, 0);
    tick(5);
    applyStimulus(3'b011, 0, 0, 0);
    tick(30);
    checkOutput("glitch_hall", 32'(hall_out), 32'h3);

    // Start forward: 32 cycles of dead-time, then RUN with sign=1
    applyStimulus(3'b011, 1, 1, 0);
    tick(1);
    checkOutput("start_dt", 32'(state), 32'd2);
    tick(31);
    checkOutput("start_dt_end", 32'(drive_en), 32'd0);
    tick(1);
    checkOutput("start_run", 32'(state), 32'd1);
    checkOutput("start_drive", 32'(drive_en), 32'd1);
    checkOutput("start_sign", 32'(sign), 32'd1);

    // Reversal: drive drops at once, sign flips only at dead-time exit
    applyStimulus(3'b011, 1, 0, 0);
    tick(1);
    checkOutput("rev_drive", 32'(drive_en), 32'd0);
    checkOutput("rev_sign_hold", 32'(sign), 32'd1);
    tick(31);
    checkOutput("rev_sign_late", 32'(sign), 32'd1);
    tick(1);
    checkOutput("rev_sign_new", 32'(sign), 32'd0);
    checkOutput("rev_run", 32'(state), 32'd1);

    // Invalid hall in RUN faults; clear only counts with run_req low
    applyStimulus(3'b111, 1, 0, 0);
    tick(20);
    checkOutput("inv_fault", 32'(fault), 32'd1);
    applyStimulus(3'b111, 1, 0, 1);
    tick(1);
    checkOutput("clr_ignored", 32'(state), 32'd3);
    applyStimulus(3'b111, 0, 0, 1);
    tick(1);
    checkOutput("clr_idle", 32'(state), 32'd0);
    applyStimulus(3'b001, 0, 0, 0);
    tick(30);

    // Stall: frozen hall faults on the STALL-th RUN cycle
    applyStimulus(3'b001, 1, 0, 0);
    tick(132);
    checkOutput("stall_pre", 32'(state), 32'd1);
    tick(1);
    checkOutput("stall_fault", 32'(state), 32'd3);
    applyStimulus(3'b001, 0, 0, 1);
    tick(5);

`ifdef BLDC_SPEED_MEAS_EN
    // Commutations 500 cycles apart while idle
    applyStimulus(3'b010, 0, 0, 0);
    tick(500);
    applyStimulus(3'b011, 0, 0, 0);
    tick(19);
    checkOutput("period_500", 32'(period), 32'd500);
`endif

    // Randomized traffic
    for (int seg = 0; seg < 80; seg++) begin
      logic [2:0] h;
      h = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 3'b000 : 3'b111)
                                      : 3'($urandom_range(1, 6));
      applyStimulus(h, ($urandom_range(0, 4) != 0), ($urandom_range(0, 3) == 0) ? ~dir_req : dir_req,
                    ($urandom_range(0, 2) == 0));
      tick($urandom_range(1, 80));
    end

    // Return to IDLE, enter DEADTIME, then reset asynchronously mid-dead-time
    applyStimulus(3'b001, 0, 0, 1);
    tick(40);
    applyStimulus(3'b001, 0, 0, 1);
    tick(40);
    checkOutput("pre_rst_idle", 32'(state), 32'd0);
    applyStimulus(3'b001, 1, 1, 0);
    tick(10);
    checkOutput("pre_rst_dt", 32'(state), 32'd2);
    applyStimulus(3'b011, 1, 1, 0);
    tick(5);
    #2 rst = 1'b1;
    #1 checkResetValues("async_rst");
    repeat (3) @(negedge clk);
    checkResetValues("held_rst");
    rst = 1'b0;
    modelReset();
    tick(60);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
